// File: rtl/tempsense_pkg.sv
// rtl/tempsense_pkg.sv - shared state type and constants for the tempsense delay-line sensor controller
package tempsense_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } ts_state_t;

    localparam int DEF_DAC_RESOLUTION   = 6;
    localparam int DEF_COUNT_WIDTH      = 12;
    localparam int DEF_PRECHARGE_CYCLES = 4;
    localparam int DEF_AVG_LOG2         = 2;

    // Saturation value of an unsigned counter of the given width (all ones).
    function automatic logic [31:0] sat_value(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/tempsense_sync2.sv
// rtl/tempsense_sync2.sv - two-flop synchronizer for asynchronous analog-macro outputs, resets to 1
module tempsense_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/tempsense_ctrl.sv
// rtl/tempsense_ctrl.sv - tempsense measurement controller: precharge, count delay, report result
// TEMPSENSE_CTRL_AVG_EN: run 2^AVG_LOG2 conversions per start and report their truncated mean.
module tempsense_ctrl
    import tempsense_pkg::*;
#(
    parameter int DAC_RESOLUTION   = DEF_DAC_RESOLUTION,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
    parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES
`ifdef TEMPSENSE_CTRL_AVG_EN
    ,
    parameter int AVG_LOG2         = DEF_AVG_LOG2
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [DAC_RESOLUTION-1:0] i_dac_code,
    output logic [DAC_RESOLUTION-1:0] o_dac_data,
    output logic                      o_dac_en,
    output logic                      o_precharge_n,
    input  logic                      i_tempdelay,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [COUNT_WIDTH-1:0]    o_result,
    output logic                      o_timeout
);

    localparam int PC_W = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRECHARGE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_SAT = COUNT_WIDTH'(sat_value(COUNT_WIDTH));

    ts_state_t              state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [PC_W-1:0]        pc_cnt;
    logic                   td_s;

    tempsense_sync2 u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_tempdelay),
        .o_q     (td_s)
    );

`ifdef TEMPSENSE_CTRL_AVG_EN
    localparam int ACC_W  = COUNT_WIDTH + AVG_LOG2;
    localparam int CONV_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [CONV_W-1:0] conv_idx;

    assign acc_next = acc + ACC_W'(cnt);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pc_cnt        <= '0;
            o_dac_data    <= '0;
            o_dac_en      <= 1'b0;
            o_precharge_n <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_result      <= '0;
            o_timeout     <= 1'b0;
`ifdef TEMPSENSE_CTRL_AVG_EN
            acc           <= '0;
            conv_idx      <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_dac_en      <= 1'b0;
                    o_precharge_n <= 1'b0;
                    if (i_start) begin
                        o_dac_data <= i_dac_code;
                        cnt        <= '0;
                        pc_cnt     <= '0;
                        o_dac_en   <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= PRECHARGE;
`ifdef TEMPSENSE_CTRL_AVG_EN
                        acc        <= '0;
                        conv_idx   <= '0;
`endif
                    end
                end

                PRECHARGE: begin
                    if (pc_cnt == PC_LAST) begin
                        cnt           <= '0;
                        o_precharge_n <= 1'b1;
                        state         <= MEASURE;
                    end else begin
                        pc_cnt <= pc_cnt + 1'b1;
                    end
                end

                MEASURE: begin
                    // td_s low wins over saturation when both happen in the same cycle.
                    if (!td_s) begin
`ifdef TEMPSENSE_CTRL_AVG_EN
                        if (conv_idx == CONV_LAST) begin
                            o_result      <= acc_next[ACC_W-1:AVG_LOG2];
                            o_timeout     <= 1'b0;
                            o_done        <= 1'b1;
                            o_dac_en      <= 1'b0;
                            o_precharge_n <= 1'b0;
                            state         <= DONE;
                        end else begin
                            acc           <= acc_next;
                            conv_idx      <= conv_idx + 1'b1;
                            pc_cnt        <= '0;
                            o_precharge_n <= 1'b0;
                            state         <= PRECHARGE;
                        end
`else
                        o_result      <= cnt;
                        o_timeout     <= 1'b0;
                        o_done        <= 1'b1;
                        o_dac_en      <= 1'b0;
                        o_precharge_n <= 1'b0;
                        state         <= DONE;
`endif
                    end else if (cnt == CNT_SAT) begin
                        o_result      <= CNT_SAT;
                        o_timeout     <= 1'b1;
                        o_done        <= 1'b1;
                        o_dac_en      <= 1'b0;
                        o_precharge_n <= 1'b0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    o_dac_en      <= 1'b0;
                    o_precharge_n <= 1'b0;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tempsense_ctrl.sv
// tb/tb_tempsense_ctrl.sv - randomized self-checking bench for tempsense_ctrl with a delay-line sensor model
module tb_tempsense_ctrl;

    localparam int DAC_W = 6;
    localparam int CW    = 4;
    localparam int P     = 4;
    localparam int SAT   = (1 << CW) - 1;
`ifdef TEMPSENSE_CTRL_AVG_EN
    localparam int AVG_L = 2;
    localparam int NCONV = 1 << AVG_L;
`else
    localparam int NCONV = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DAC_W-1:0] dac_code = '0;
    logic             tempdelay = 1'b1;

    logic [DAC_W-1:0] o_dac_data;
    logic             o_dac_en;
    logic             o_precharge_n;
    logic             o_busy;
    logic             o_done;
    logic [CW-1:0]    o_result;
    logic             o_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int delay_q[$];
    int model_k = 0;
    int model_cur = 0;

    tempsense_ctrl #(
        .DAC_RESOLUTION   (DAC_W),
        .COUNT_WIDTH      (CW),
        .PRECHARGE_CYCLES (P)
`ifdef TEMPSENSE_CTRL_AVG_EN
        ,
        .AVG_LOG2         (AVG_L)
`endif
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dac_code    (dac_code),
        .o_dac_data    (o_dac_data),
        .o_dac_en      (o_dac_en),
        .o_precharge_n (o_precharge_n),
        .i_tempdelay   (tempdelay),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sensor: output high while precharged, falls N cycles after precharge release.
    always @(posedge clk) begin
        #1;
        if (!o_precharge_n) begin
            tempdelay = 1'b1;
            model_k   = 0;
        end else begin
            if (model_k == 0)
                model_cur = (delay_q.size() > 0) ? delay_q.pop_front() : (1 << 20);
            if (model_k == model_cur)
                tempdelay = 1'b0;
            model_k++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (o_done === 1'b1)
            done_cnt++;
    end

    // One start; dl holds the per-conversion delays, inject_at > 0 pulses a start with code 3F at that edge.
    task automatic run_conv(input logic [DAC_W-1:0] code, input int dl[4], input int inject_at,
                            input string tag);
        int exp_res, exp_to, exp_edge, sum, d0, seen, dac_bad, busy_bad;
        exp_edge = 0;
        sum      = 0;
        exp_to   = 0;
        for (int i = 0; i < NCONV; i++) begin
            delay_q.push_back(dl[i]);
            if (dl[i] + 2 > SAT) begin
                exp_to   = 1;
                exp_edge = exp_edge + P + SAT + 1;
                break;
            end
            sum      = sum + dl[i] + 2;
            exp_edge = exp_edge + P + dl[i] + 3;
        end
        exp_res  = exp_to ? SAT : sum / NCONV;
        d0       = done_cnt;
        dac_bad  = 0;
        busy_bad = 0;
        seen     = -1;

        dac_code = code;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o_dac_data !== code) dac_bad++;
        if (o_busy !== 1'b1) busy_bad++;

        for (int k = 1; k <= exp_edge + 20 && seen < 0; k++) begin
            if (k == inject_at) begin
                start    = 1'b1;
                dac_code = '1;
            end
            @(posedge clk);
            #1;
            if (k == inject_at) begin
                start    = 1'b0;
                dac_code = code;
            end
            if (o_dac_data !== code) dac_bad++;
            if (o_busy !== 1'b1) busy_bad++;
            if (o_done === 1'b1) seen = k;
        end

        check({tag, "_latency"}, 32'(seen), 32'(exp_edge));
        check({tag, "_result"}, 32'(o_result), 32'(exp_res));
        check({tag, "_timeout"}, 32'(o_timeout), 32'(exp_to));
        check({tag, "_dac_data_hold"}, 32'(dac_bad), 0);
        check({tag, "_busy_hold"}, 32'(busy_bad), 0);

        @(posedge clk);
        #1;
        check({tag, "_idle_outputs"}, 32'({o_done, o_precharge_n, o_dac_en, o_busy}), 0);
        check({tag, "_result_held"}, 32'(o_result), 32'(exp_res));
        #1;
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
        delay_q.delete();
    endtask

    initial begin
        int dl[4];
        int inj;
        int idle_bad;
        int d0;
        logic [DAC_W-1:0] code;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_dac_data", 32'(o_dac_data), 0);
        check("rst_dac_en", 32'(o_dac_en), 0);
        check("rst_precharge_n", 32'(o_precharge_n), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_result", 32'(o_result), 0);
        check("rst_timeout", 32'(o_timeout), 0);

        @(negedge clk);
        rst_n    = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if ({o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done, o_result, o_timeout} !== '0)
                idle_bad++;
        end
        check("idle_stable", 32'(idle_bad), 0);

        run_conv(6'h04, '{10, 10, 10, 10}, 0, "nominal");
        run_conv(6'h15, '{8, 9, 10, 11}, 0, "avg_set");
        run_conv(6'h2A, '{20, 20, 20, 20}, 0, "timeout");
        run_conv(6'h01, '{13, 13, 13, 13}, 0, "max_no_sat");
        run_conv(6'h02, '{14, 14, 14, 14}, 0, "first_sat");
        run_conv(6'h03, '{0, 0, 0, 0}, 0, "zero_delay");
        run_conv(6'h07, '{6, 5, 4, 3}, P + 3, "start_busy");
        run_conv(6'h08, '{3, 9, 20, 1}, 0, "late_sat");

        // Reset in the middle of MEASURE
        delay_q.push_back(12);
        dac_code = 6'h05;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (P + 3) @(posedge clk);
        #3;
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done, o_result, o_timeout}), 0);
        repeat (5) @(posedge clk);
        #2;
        check("midrst_no_done", 32'(done_cnt - d0), 0);
        delay_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_conv(6'h04, '{10, 10, 10, 10}, 0, "after_rst");

        for (int r = 0; r < 12; r++) begin
            code = DAC_W'($urandom_range(0, 62));
            for (int i = 0; i < 4; i++)
                dl[i] = $urandom_range(0, 16);
            inj = ($urandom_range(0, 1) == 1) ? (P + 1 + $urandom_range(0, (dl[0] < 10) ? dl[0] : 10)) : 0;
            run_conv(code, dl, inj, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
